// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg : shared FSM state type and nibble constants (Rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package adder_pkg;

  localparam int NIB = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int num_nib(input int width);
    return width / NIB;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fourbit_s.sv
// ---------------------------------------------------------------------------
// fourbit_s : 4-bit carry-select adder slice (Rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module fourbit_s (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] s_o,
  output logic       cout_o
);

  logic [2:0] w_lo;
  logic [2:0] w_hi0;
  logic [2:0] w_hi1;
  logic [2:0] w_hi;

  // Upper pair is computed for both carry values and picked by the lower carry.
  always_comb begin
    w_lo   = {1'b0, a_i[1:0]} + {1'b0, b_i[1:0]} + {2'b00, cin_i};
    w_hi0  = {1'b0, a_i[3:2]} + {1'b0, b_i[3:2]};
    w_hi1  = {1'b0, a_i[3:2]} + {1'b0, b_i[3:2]} + 3'd1;
    w_hi   = w_lo[2] ? w_hi1 : w_hi0;
    s_o    = {w_hi[1:0], w_lo[1:0]};
    cout_o = w_hi[2];
  end

endmodule

`default_nettype wire

// File: rtl/nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder : multi-cycle adder, one nibble per cycle, LSB first (Rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int NUM_NIB = num_nib(WIDTH);
  localparam int CNT_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_NIB - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [NIB-1:0]   slice_s;
  logic             slice_cout;
  logic [WIDTH-1:0] acc_next;

  fourbit_s u_slice (
    .a_i    (a_sh_q[NIB-1:0]),
    .b_i    (b_sh_q[NIB-1:0]),
    .cin_i  (carry_q),
    .s_o    (slice_s),
    .cout_o (slice_cout)
  );

  assign acc_next = {slice_s, acc_q[WIDTH-1:NIB]};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      carry_q <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      carry_q <= carry_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    carry_d = carry_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE accepts a new op exactly like IDLE so ops can run back to back.
        if (Start) begin
          a_sh_d  = A;
          b_sh_d  = B;
          carry_d = Cin;
          count_d = '0;
          acc_d   = '0;
          state_d = ST_ADD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADD: begin
        acc_d   = acc_next;
        carry_d = slice_cout;
        a_sh_d  = a_sh_q >> NIB;
        b_sh_d  = b_sh_q >> NIB;
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST_CNT) begin
          sum_d   = acc_next;
          cout_d  = slice_cout;
          count_d = '0;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign Busy = (state_q == ST_ADD);
  assign Done = (state_q == ST_DONE);
  assign Sum  = sum_q;
  assign Cout = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_adder : self-checking bench for nibble_serial_adder (Rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_nibble_serial_adder;

  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic [15:0] A, B;
  logic        Cin;
  logic        Busy, Done, Cout;
  logic [15:0] Sum;

  int checks   = 0;
  int failures = 0;

  logic [15:0] prev_s;
  logic        prev_c;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Start   (Start),
    .A       (A),
    .B       (B),
    .Cin     (Cin),
    .Busy    (Busy),
    .Done    (Done),
    .Sum     (Sum),
    .Cout    (Cout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // One full op: 4 busy cycles with held previous result, then a one-cycle Done.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input bit disturb, input string name);
    logic [16:0] exp;
    exp = {1'b0, a} + {1'b0, b} + {16'd0, ci};
    @(negedge Clk);
    A = a; B = b; Cin = ci; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (Busy !== 1'b1 || Done !== 1'b0 || Sum !== prev_s || Cout !== prev_c) begin
        failures++;
        $display("FAIL %s add_cycle%0d: busy=%b done=%b sum=%h cout=%b, want busy=1 done=0 sum=%h cout=%b",
                 name, i, Busy, Done, Sum, Cout, prev_s, prev_c);
      end
      if (disturb && i < 3) begin
        Start = 1'b1; A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom);
      end
      @(posedge Clk); #1;
      Start = 1'b0;
    end
    checks++;
    if (Done !== 1'b1 || Busy !== 1'b0 || Sum !== exp[15:0] || Cout !== exp[16]) begin
      failures++;
      $display("FAIL %s result: done=%b busy=%b sum=%h cout=%b, want done=1 busy=0 sum=%h cout=%b",
               name, Done, Busy, Sum, Cout, exp[15:0], exp[16]);
    end
    prev_s = exp[15:0];
    prev_c = exp[16];
    @(posedge Clk); #1;
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0 || Sum !== prev_s || Cout !== prev_c) begin
      failures++;
      $display("FAIL %s after_done: done=%b busy=%b sum=%h cout=%b, want done=0 busy=0 sum=%h cout=%b",
               name, Done, Busy, Sum, Cout, prev_s, prev_c);
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; Start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    prev_s = '0; prev_c = 1'b0;
    #2;
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Sum !== 16'h0 || Cout !== 1'b0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b sum=%h cout=%b, want all zero", Busy, Done, Sum, Cout);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_directed();
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, "basic");
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "ripple");
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, "cin_ripple");
    run_op(16'h0F0F, 16'hF0F0, 1'b0, 1'b0, "alt_nibbles");
  endtask

  task automatic test_ignore_during_add();
    run_op(16'hA5C3, 16'h1E77, 1'b1, 1'b1, "start_in_add");
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, "random");
  endtask

  task automatic test_back_to_back();
    logic exp_done;
    @(negedge Clk);
    A = 16'h0001; B = 16'h0001; Cin = 1'b0; Start = 1'b1;
    @(posedge Clk);
    for (int j = 1; j <= 14; j++) begin
      @(posedge Clk); #1;
      exp_done = ((j % 5) == 4);
      checks++;
      if (Done !== exp_done || Busy !== !exp_done || (exp_done && (Sum !== 16'h0002 || Cout !== 1'b0))) begin
        failures++;
        $display("FAIL back_to_back cycle%0d: done=%b busy=%b sum=%h cout=%b, want done=%b busy=%b sum=0002 on done",
                 j, Done, Busy, Sum, Cout, exp_done, !exp_done);
      end
    end
    Start = 1'b0;
    prev_s = 16'h0002; prev_c = 1'b0;
    repeat (6) @(posedge Clk);
  endtask

  task automatic test_reset_mid_add();
    @(negedge Clk);
    A = 16'h7777; B = 16'h8888; Cin = 1'b1; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    @(posedge Clk); #3;
    Reset_n = 1'b0;
    #1;
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Sum !== 16'h0 || Cout !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_add: busy=%b done=%b sum=%h cout=%b, want all zero", Busy, Done, Sum, Cout);
    end
    prev_s = '0; prev_c = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge Clk); #1;
      checks++;
      if (Done !== 1'b0 || Busy !== 1'b0 || Sum !== 16'h0) begin
        failures++;
        $display("FAIL post_reset_idle cycle%0d: done=%b busy=%b sum=%h, want 0 0 0000", k, Done, Busy, Sum);
      end
    end
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_during_add();
    test_random();
    test_back_to_back();
    test_reset_mid_add();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
